// File: rtl/cv32e40px_apu_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40px_apu_arbiter
//
// Shares one APU between NUM_REQ core-side APU dispatchers. Requests are
// arbitrated round-robin. The selection is locked while the APU
// back-pressures, so the forwarded payload cannot change under a stall.
// An in-order tag FIFO of requester IDs steers each returning result back
// to the requester that issued it.
//
// Handshake semantics (all interfaces):
//   A requester raises req_i and holds it, with a stable payload_i, until it
//   sees gnt_o in that cycle. The request/grant pair completes in the cycle
//   where both are high; grant may arrive in the same cycle the request rises.
//   Toward the APU, apu_req_o/apu_gnt_i follow the same rule. Results carry
//   no back-pressure: apu_rvalid_i and rvalid_o are single-cycle pulses, and
//   results return in issue order.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i, payload_i    per-requester request and packed payload
//   gnt_o               one-hot grant (combinational)
//   rvalid_o, result_o  one-hot result valid, broadcast result bundle
//   apu_req_o, apu_payload_o, apu_gnt_i   request side of the APU port
//   apu_rvalid_i, apu_result_i            response side of the APU port
//   outstanding_o       tag FIFO occupancy
//   err_o               sticky protocol error (cleared only by reset)
// ---------------------------------------------------------------------------
module cv32e40px_apu_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int PAYLOAD_W       = 128,
  parameter int RESULT_W        = 37,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]       payload_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [RESULT_W-1:0]                result_o,
  output logic                               apu_req_o,
  output logic [PAYLOAD_W-1:0]               apu_payload_o,
  input  logic                               apu_gnt_i,
  input  logic                               apu_rvalid_i,
  input  logic [RESULT_W-1:0]                apu_result_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  // Architectural state
  logic [ID_W-1:0]  ptr_q;       // round-robin priority pointer
  logic             lock_q;      // selection frozen under back-pressure
  logic [ID_W-1:0]  lock_idx_q;  // requester held by the lock
  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Combinational decode
  logic [ID_W-1:0]  rr_sel;
  logic             rr_found;
  logic [ID_W-1:0]  scan_idx;
  logic [ID_W-1:0]  sel;
  logic             lock_hold;
  logic             lock_drop;
  logic             full;
  logic             fifo_empty;
  logic             handshake;
  logic             pop;
  logic             empty_err;
  logic [ID_W-1:0]  head_id;
  logic [ID_W-1:0]  ptr_nxt;

  assign full       = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head_id    = fifo_q[rd_ptr_q];

  // A locked requester that withdraws its request without a grant is a
  // protocol violation; the lock is released and arbitration proceeds
  // unlocked in the same cycle.
  assign lock_hold = lock_q &  req_i[lock_idx_q];
  assign lock_drop = lock_q & ~req_i[lock_idx_q];

  // Round-robin scan: ptr, ptr+1, ..., wrapping at NUM_REQ.
  always_comb begin
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!rr_found && req_i[scan_idx]) begin
        rr_sel   = scan_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign sel = lock_hold ? lock_idx_q : rr_sel;

  // Outputs are forced low while reset is asserted, since they are
  // combinational functions of live inputs.
  assign apu_req_o = (|req_i) & ~full & ~rst_i;
  assign handshake = apu_req_o & apu_gnt_i;
  assign pop       = apu_rvalid_i & ~fifo_empty & ~rst_i;
  assign empty_err = apu_rvalid_i & fifo_empty;

  assign ptr_nxt = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);

  always_comb begin
    apu_payload_o = payload_i[PAYLOAD_W-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == ID_W'(i)) begin
        apu_payload_o = payload_i[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (handshake) begin
      gnt_o[sel] = 1'b1;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (pop) begin
      rvalid_o[head_id] = 1'b1;
    end
  end

  assign result_o      = apu_result_i;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      // Lock / priority pointer
      if (handshake) begin
        lock_q <= 1'b0;
        ptr_q  <= ptr_nxt;
      end else if (apu_req_o) begin
        // Back-pressure: freeze the current selection.
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end else if (lock_drop) begin
        lock_q <= 1'b0;
      end

      // Tag FIFO
      if (handshake) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({handshake, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase

      if (lock_drop || empty_err) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40px_apu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cv32e40px_apu_arbiter
//
// Directed self-checking bench for cv32e40px_apu_arbiter (NUM_REQ=4,
// MAX_OUTSTANDING=4). Inputs change 1 ns after the rising edge and outputs
// are sampled 1 ns later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_cv32e40px_apu_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int PAYLOAD_W = 128;
  localparam int RESULT_W  = 37;
  localparam int MAX_OUT   = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [NUM_REQ-1:0]           req_i = '0;
  logic [NUM_REQ*PAYLOAD_W-1:0] payload_i = '0;
  logic [NUM_REQ-1:0]           gnt_o;
  logic [NUM_REQ-1:0]           rvalid_o;
  logic [RESULT_W-1:0]          result_o;
  logic                         apu_req_o;
  logic [PAYLOAD_W-1:0]         apu_payload_o;
  logic                         apu_gnt_i = 1'b0;
  logic                         apu_rvalid_i = 1'b0;
  logic [RESULT_W-1:0]          apu_result_i = '0;
  logic [$clog2(MAX_OUT):0]     outstanding_o;
  logic                         err_o;

  cv32e40px_apu_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .PAYLOAD_W      (PAYLOAD_W),
    .RESULT_W       (RESULT_W),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .payload_i    (payload_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .result_o     (result_o),
    .apu_req_o    (apu_req_o),
    .apu_payload_o(apu_payload_o),
    .apu_gnt_i    (apu_gnt_i),
    .apu_rvalid_i (apu_rvalid_i),
    .apu_result_i (apu_result_i),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [NUM_REQ-1:0] exp_q[$];

  function automatic logic [PAYLOAD_W-1:0] pl(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_i        = '0;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    req_i = 4'b1111; apu_gnt_i = 1'b1; apu_rvalid_i = 1'b1;
    step();
    n_chk++; if (gnt_o !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt_o); else n_pass++;
    n_chk++; if (apu_req_o !== 1'b0) $display("FAIL reset_apu_req: got %b want 0", apu_req_o); else n_pass++;
    n_chk++; if (rvalid_o !== 4'b0000) $display("FAIL reset_rvalid: got %b want 0000", rvalid_o); else n_pass++;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL reset_occ: got %0d want 0", outstanding_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    idle();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    // req2 under back-pressure; ptr=0 so an unlocked scan would prefer req0.
    req_i = 4'b0100; apu_gnt_i = 1'b0; #1;
    n_chk++; if (apu_req_o !== 1'b1) $display("FAIL lock_apu_req: got %b want 1", apu_req_o); else n_pass++;
    n_chk++; if (apu_payload_o !== pl(2)) $display("FAIL lock_pl_c1: got %h want %h", apu_payload_o, pl(2)); else n_pass++;
    step();
    req_i = 4'b0101; #1;
    n_chk++; if (apu_payload_o !== pl(2)) $display("FAIL lock_pl_c2: got %h want %h", apu_payload_o, pl(2)); else n_pass++;
    n_chk++; if (gnt_o !== 4'b0000) $display("FAIL lock_gnt_c2: got %b want 0000", gnt_o); else n_pass++;
    step();
    #1;
    n_chk++; if (apu_payload_o !== pl(2)) $display("FAIL lock_pl_c3: got %h want %h", apu_payload_o, pl(2)); else n_pass++;
    step();
    apu_gnt_i = 1'b1; #1;
    n_chk++; if (gnt_o !== 4'b0100) $display("FAIL lock_gnt_release: got %b want 0100", gnt_o); else n_pass++;
    step();
    req_i = 4'b0001; #1;
    n_chk++; if (gnt_o !== 4'b0001) $display("FAIL lock_gnt_next: got %b want 0001", gnt_o); else n_pass++;
    step();
    idle(); apu_rvalid_i = 1'b1; #1;
    n_chk++; if (rvalid_o !== 4'b0100) $display("FAIL lock_rv0: got %b want 0100", rvalid_o); else n_pass++;
    step(); #1;
    n_chk++; if (rvalid_o !== 4'b0001) $display("FAIL lock_rv1: got %b want 0001", rvalid_o); else n_pass++;
    step();
    idle(); #1;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL lock_occ_end: got %0d want 0", outstanding_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL lock_err: got %b want 0", err_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [3:0] exp_r [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    req_i = 4'b1111; apu_gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      apu_rvalid_i = (k > 0); #1;
      n_chk++; if (gnt_o !== exp_g[k]) $display("FAIL rr_gnt%0d: got %b want %b", k, gnt_o, exp_g[k]); else n_pass++;
      n_chk++; if (rvalid_o !== exp_r[k]) $display("FAIL rr_rv%0d: got %b want %b", k, rvalid_o, exp_r[k]); else n_pass++;
      step();
    end
    req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1; #1;
    n_chk++; if (rvalid_o !== 4'b0001) $display("FAIL rr_rv_last: got %b want 0001", rvalid_o); else n_pass++;
    step();
    idle(); #1;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL rr_occ_end: got %0d want 0", outstanding_o); else n_pass++;
  endtask

  task automatic test_full_stall();
    logic [3:0] exp_g [4];
    logic [3:0] exp_r [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_r = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req_i = 4'b1111; apu_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (gnt_o !== exp_g[k]) $display("FAIL full_gnt%0d: got %b want %b", k, gnt_o, exp_g[k]); else n_pass++;
      step();
    end
    #1;
    n_chk++; if (outstanding_o !== 3'd4) $display("FAIL full_occ4: got %0d want 4", outstanding_o); else n_pass++;
    n_chk++; if (apu_req_o !== 1'b0) $display("FAIL full_apu_req: got %b want 0", apu_req_o); else n_pass++;
    n_chk++; if (gnt_o !== 4'b0000) $display("FAIL full_gnt_stall: got %b want 0000", gnt_o); else n_pass++;
    step();
    apu_rvalid_i = 1'b1; #1;
    n_chk++; if (rvalid_o !== 4'b0001) $display("FAIL full_rv_pop: got %b want 0001", rvalid_o); else n_pass++;
    n_chk++; if (apu_req_o !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", apu_req_o); else n_pass++;
    step();
    apu_rvalid_i = 1'b0; #1;
    n_chk++; if (outstanding_o !== 3'd3) $display("FAIL full_occ3: got %0d want 3", outstanding_o); else n_pass++;
    n_chk++; if (apu_req_o !== 1'b1) $display("FAIL full_apu_req_resume: got %b want 1", apu_req_o); else n_pass++;
    n_chk++; if (gnt_o !== 4'b0001) $display("FAIL full_gnt_resume: got %b want 0001", gnt_o); else n_pass++;
    step();
    idle(); apu_rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (rvalid_o !== exp_r[k]) $display("FAIL full_drain%0d: got %b want %b", k, rvalid_o, exp_r[k]); else n_pass++;
      step();
    end
    apu_rvalid_i = 1'b0; #1;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL full_occ_end: got %0d want 0", outstanding_o); else n_pass++;
  endtask

  task automatic test_in_order();
    logic [3:0]          reqs [3];
    logic [RESULT_W-1:0] results [3];
    logic [3:0]          exp_id;
    reqs    = '{4'b1000, 4'b0010, 4'b1000};
    results = '{37'h01_2345_6789, 37'h1F_FFFF_FFFF, 37'h00_0000_00A5};
    do_reset();
    apu_gnt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_i = reqs[k]; #1;
      n_chk++; if (gnt_o !== reqs[k]) $display("FAIL ord_gnt%0d: got %b want %b", k, gnt_o, reqs[k]); else n_pass++;
      exp_q.push_back(reqs[k]);
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      apu_rvalid_i = 1'b1; apu_result_i = results[k]; #1;
      exp_id = exp_q.pop_front();
      n_chk++; if (rvalid_o !== exp_id) $display("FAIL ord_rv%0d: got %b want %b", k, rvalid_o, exp_id); else n_pass++;
      n_chk++; if (result_o !== results[k]) $display("FAIL ord_res%0d: got %h want %h", k, result_o, results[k]); else n_pass++;
      step();
      apu_rvalid_i = 1'b0; #1;
      n_chk++; if (rvalid_o !== 4'b0000) $display("FAIL ord_gap%0d: got %b want 0000", k, rvalid_o); else n_pass++;
      step();
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    apu_gnt_i = 1'b1;
    req_i = 4'b0001; step();
    req_i = 4'b0010; step();
    req_i = 4'b0100; apu_rvalid_i = 1'b1; #1;
    n_chk++; if (gnt_o !== 4'b0100) $display("FAIL pp_gnt: got %b want 0100", gnt_o); else n_pass++;
    n_chk++; if (rvalid_o !== 4'b0001) $display("FAIL pp_rv_head: got %b want 0001", rvalid_o); else n_pass++;
    step();
    idle(); #1;
    n_chk++; if (outstanding_o !== 3'd2) $display("FAIL pp_occ: got %0d want 2", outstanding_o); else n_pass++;
    apu_rvalid_i = 1'b1; #1;
    n_chk++; if (rvalid_o !== 4'b0010) $display("FAIL pp_rv1: got %b want 0010", rvalid_o); else n_pass++;
    step(); #1;
    n_chk++; if (rvalid_o !== 4'b0100) $display("FAIL pp_rv2: got %b want 0100", rvalid_o); else n_pass++;
    step();
    idle(); #1;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL pp_occ_end: got %0d want 0", outstanding_o); else n_pass++;
  endtask

  task automatic test_errors_reset();
    do_reset();
    apu_rvalid_i = 1'b1; #1;
    n_chk++; if (rvalid_o !== 4'b0000) $display("FAIL err_rv_empty: got %b want 0000", rvalid_o); else n_pass++;
    step();
    apu_rvalid_i = 1'b0; #1;
    n_chk++; if (err_o !== 1'b1) $display("FAIL err_set: got %b want 1", err_o); else n_pass++;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL err_no_underflow: got %0d want 0", outstanding_o); else n_pass++;
    req_i = 4'b1111; apu_gnt_i = 1'b1;
    step(); step(); step();
    idle(); #1;
    n_chk++; if (outstanding_o !== 3'd3) $display("FAIL err_occ3: got %0d want 3", outstanding_o); else n_pass++;
    // Asynchronous reset in mid-cycle with requests pending.
    req_i = 4'b1111; apu_gnt_i = 1'b1;
    rst_i = 1'b1; #1;
    n_chk++; if (outstanding_o !== 3'd0) $display("FAIL rst_occ: got %0d want 0", outstanding_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
    n_chk++; if (gnt_o !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", gnt_o); else n_pass++;
    step();
    rst_i = 1'b0; apu_rvalid_i = 1'b1; #1;
    n_chk++; if (gnt_o !== 4'b0001) $display("FAIL rst_gnt_ptr0: got %b want 0001", gnt_o); else n_pass++;
    n_chk++; if (rvalid_o !== 4'b0000) $display("FAIL rst_stale_rv: got %b want 0000", rvalid_o); else n_pass++;
    step();
    idle(); #1;
    n_chk++; if (err_o !== 1'b1) $display("FAIL rst_stale_err: got %b want 1", err_o); else n_pass++;
    n_chk++; if (outstanding_o !== 3'd1) $display("FAIL rst_occ1: got %0d want 1", outstanding_o); else n_pass++;
  endtask

  task automatic test_lock_drop();
    do_reset();
    req_i = 4'b0010; apu_gnt_i = 1'b0; #1;
    n_chk++; if (apu_payload_o !== pl(1)) $display("FAIL drop_pl1: got %h want %h", apu_payload_o, pl(1)); else n_pass++;
    step();
    req_i = 4'b0100; #1;
    n_chk++; if (apu_payload_o !== pl(2)) $display("FAIL drop_pl2: got %h want %h", apu_payload_o, pl(2)); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL drop_err_pre: got %b want 0", err_o); else n_pass++;
    step(); #1;
    n_chk++; if (err_o !== 1'b1) $display("FAIL drop_err_set: got %b want 1", err_o); else n_pass++;
    idle();
    step();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      payload_i[i*PAYLOAD_W +: PAYLOAD_W] = pl(i);
    end
    test_reset();
    test_lock();
    test_round_robin();
    test_full_stall();
    test_in_order();
    test_push_pop();
    test_errors_reset();
    test_lock_drop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/cv32e40px_apu_arbiter.md
Name: cv32e40px_apu_arbiter

Overview:
- Shares one APU (FPU / shared arithmetic unit) between NUM_REQ core-side APU dispatchers.
- Round-robin arbitration of request/grant handshakes, with the selection locked while the APU back-pressures.
- An in-order tag FIFO of requester IDs routes each returning result to the requester that issued it.
- Sits between the per-core dispatchers and the APU interconnect port.

Parameters:
- NUM_REQ, 4, number of requesting cores (2..8).
- PAYLOAD_W, 128, width of the op/operand/flag bundle forwarded to the APU.
- RESULT_W, 37, width of the result plus flags bundle returned by the APU.
- MAX_OUTSTANDING, 4, tag FIFO depth; must be a power of two, >=2.
- ID_W, $clog2(NUM_REQ), requester-ID width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request; held high until granted.
- payload_i  in  NUM_REQ*PAYLOAD_W  per-requester payload; stable while req_i is high.
- gnt_o  out  NUM_REQ  one-hot grant; combinational.
- rvalid_o  out  NUM_REQ  one-hot result valid, one cycle per result.
- result_o  out  RESULT_W  result bundle, broadcast to all requesters, qualified by rvalid_o.
- apu_req_o  out  1  request to the APU.
- apu_payload_o  out  PAYLOAD_W  payload of the selected requester.
- apu_gnt_i  in  1  APU accepts the request this cycle.
- apu_rvalid_i  in  1  APU result valid; results return in issue order.
- apu_result_i  in  RESULT_W  APU result bundle.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i high, asynchronous): FIFO emptied, occupancy 0, priority pointer = 0, lock cleared, err_o = 0. gnt_o, rvalid_o and apu_req_o read 0 during reset.
- Full flag: full = (occupancy == MAX_OUTSTANDING), taken from the registered count. There is no same-cycle bypass, so a pop in a cycle does not enable a push in that same cycle when full.
- apu_req_o = |req_i & !full.
- Selection, unlocked: the first requester with req_i set, scanning from the priority pointer upward with wrap (ptr, ptr+1 … NUM_REQ-1, 0 …).
- Lock, set: in any cycle where apu_req_o=1 and apu_gnt_i=0, the lock is set and the selected index is stored.
- Lock, held: while the lock is set, the stored index is selected regardless of other req_i.
- Lock, cleared: on the handshake (apu_req_o & apu_gnt_i). apu_payload_o therefore cannot change under back-pressure.
- Lock, dropped request: if the locked requester drops req_i without a grant, the lock clears, err_o is set, and arbitration resumes unlocked in the same cycle.
- Handshake (apu_req_o & apu_gnt_i):
  - gnt_o[sel] = 1 for that cycle only.
  - The sel ID is pushed into the FIFO.
  - Priority pointer becomes (sel+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
- Zero-cycle grant: gnt_o may assert in the same cycle as req_i rises; no added latency.
- Result (apu_rvalid_i with FIFO non-empty):
  - rvalid_o[head ID] = 1 in the same cycle (combinational route).
  - result_o = apu_result_i.
  - The FIFO pops.
- Result with FIFO empty: rvalid_o stays all-zero, err_o is set, and the occupancy stays 0 (no underflow).
- Simultaneous push and pop: occupancy unchanged; head and tail pointers both advance.
- Same-cycle single-cycle op: a push and a pop of the same new entry in one cycle is not supported. An apu_rvalid_i arriving with an empty FIFO in the grant cycle counts as the empty-FIFO error above.
- FIFO pointers: ID_W-independent, $clog2(MAX_OUTSTANDING) bits wide, natural wrap. Occupancy counter is one bit wider.
- result_o drives apu_result_i unconditionally; consumers qualify it with rvalid_o.
- err_o stays high until reset.
- Reset mid-operation: all in-flight tags are discarded. Any later apu_rvalid_i is then treated as an empty-FIFO error.

Test Plan:
- Round-robin fairness: NUM_REQ=4, all req_i=4'b1111 held, apu_gnt_i=1, apu_rvalid_i=1 one cycle after each grant -> gnt_o sequence 0001, 0010, 0100, 1000, 0001.
- Lock under back-pressure: req_i[2] rises with apu_gnt_i=0 for 3 cycles; req_i[0] rises in cycle 2 -> apu_payload_o stays payload_i[2]; gnt_o=0100 when apu_gnt_i rises; req0 is granted next.
- Full stall: MAX_OUTSTANDING=4, 4 grants with no rvalid -> outstanding_o=4 and apu_req_o=0 even with req_i set. One apu_rvalid_i -> apu_req_o=1 the next cycle, not the same cycle.
- In-order routing: grants to 3, 1, 3 -> three apu_rvalid_i pulses give rvalid_o = 1000, 0010, 1000, with result_o matching each apu_result_i.
- Simultaneous push/pop: occupancy 2; a grant and an rvalid in the same cycle -> occupancy stays 2, the popped ID goes to the old head, and the new ID is at the tail.
- Errors and reset: apu_rvalid_i with an empty FIFO -> err_o=1, rvalid_o=0. Assert rst_i with occupancy 3 -> occupancy 0, err_o=0, pointer 0, and the next grant goes to req 0 when all requesters are active.
